// File: rtl/boot_loader_pkg.sv
// Shared encodings for the instruction-memory boot loader: FSM states,
// result status codes and the byte stride between instruction words.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4,
    S_FAIL = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    STAT_NONE     = 3'd0,
    STAT_PASS     = 3'd1,
    STAT_TIMEOUT  = 3'd2,
    STAT_OVERFLOW = 3'd3,
    STAT_CHECKSUM = 3'd4
  } status_e;

  localparam int unsigned ADDR_STRIDE = 4;

endpackage

// File: rtl/boot_watchdog.sv
// Run-phase cycle counter: clear_i restarts it at 0, enable_i advances it,
// expired_o flags the cycle in which the count reaches TIMEOUT-1.
module boot_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

  // Counter parks at its terminal value so it can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory, holds the CPU in reset, then
// supervises its run. Define BOOT_CHECKSUM_EN to treat the final beat as a checksum.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     imem_we,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [DATA_W-1:0]        imem_wdata,
  output logic                     cpu_reset,
  input  logic                     cpu_done,
  output logic                     busy,
  output logic [2:0]               status,
  output logic [$clog2(DEPTH):0]   words_loaded
);

  localparam int WL_W   = $clog2(DEPTH) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [WL_W-1:0]     words_q, words_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_prev_q;

  logic accept;
  logic csum_beat;
  logic done_edge;
  logic wd_expired;

`ifdef BOOT_CHECKSUM_EN
  assign csum_beat = in_last;
`else
  assign csum_beat = 1'b0;
`endif

  assign accept    = (state_q == S_LOAD) && in_valid;
  assign done_edge = cpu_done && !done_prev_q;

  boot_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != S_RUN),
    .enable_i  (state_q == S_RUN),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    words_d  = words_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sum_d    = sum_q;
    hold_d   = hold_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d  = S_LOAD;
          status_d = STAT_NONE;
          words_d  = '0;
          sum_d    = '0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          // A checksum beat is only compared, never written or summed.
          if (!csum_beat) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(words_q) * ADDR_W'(ADDR_STRIDE);
            wdata_d = in_data;
            words_d = words_q + 1'b1;
            sum_d   = sum_q + in_data;
          end
          if (in_last) begin
            hold_d = '0;
            if (csum_beat && (in_data != sum_q)) begin
              state_d  = S_FAIL;
              status_d = STAT_CHECKSUM;
            end else begin
              state_d = S_HOLD;
            end
          end else if (words_q == WL_W'(DEPTH - 1)) begin
            state_d  = S_FAIL;
            status_d = STAT_OVERFLOW;
          end
        end
      end

      S_HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RUN;
        end
      end

      // A completion edge wins over a timeout landing in the same cycle.
      S_RUN: begin
        if (done_edge) begin
          state_d  = S_DONE;
          status_d = STAT_PASS;
        end else if (wd_expired) begin
          state_d  = S_FAIL;
          status_d = STAT_TIMEOUT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      status_q    <= STAT_NONE;
      words_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sum_q       <= '0;
      hold_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      words_q     <= words_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sum_q       <= sum_d;
      hold_q      <= hold_d;
      done_prev_q <= cpu_done;
    end
  end

  assign in_ready     = (state_q == S_LOAD);
  assign cpu_reset    = !((state_q == S_RUN) || (state_q == S_DONE));
  assign busy         = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
  assign status       = status_q;
  assign words_loaded = words_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;

endmodule
